uart_tx_buffer: RTL and testbench

UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

---
 rtl/uart_tx_buffer.sv | 97 +++++++++
 tb/tb_uart_tx_buffer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffer.sv
// Character FIFO in front of a UART transmitter. A small launch FSM pops one entry
// per transmit handshake and raises a one-cycle data_valid strobe.
module uart_tx_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       wr_en,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic                       tx_busy,
    output logic [DATA_WIDTH-1:0]      p_data,
    output logic                       data_valid
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_HI, WAIT_LO} state_e;

    state_e                 state_q, state_d;
    logic [1:0]             tmr_q, tmr_d;
    logic [AW-1:0]          wptr_q, rptr_q;
    logic [CW-1:0]          count_q;
    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]  p_data_q;
    logic                   ovf_q, dv_q;
    logic                   push, pop;

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign overflow   = ovf_q;
    assign p_data     = p_data_q;
    assign data_valid = dv_q;

    assign push = wr_en && !full;
    // A pop happens only on the IDLE->LAUNCH edge, so it can never see an empty FIFO.
    assign pop  = (state_q == IDLE) && (state_d == LAUNCH);

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        case (state_q)
            IDLE:    if (!empty && !tx_busy) state_d = LAUNCH;
            LAUNCH: begin
                state_d = WAIT_HI;
                tmr_d   = 2'd0;
            end
            // Guard: give up on the handshake after two quiet cycles.
            WAIT_HI: begin
                if (tx_busy)            state_d = WAIT_LO;
                else if (tmr_q == 2'd1) state_d = IDLE;
                else                    tmr_d   = tmr_q + 2'd1;
            end
            WAIT_LO: if (!tx_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            tmr_q    <= 2'd0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            p_data_q <= '0;
            ovf_q    <= 1'b0;
            dv_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            ovf_q   <= wr_en && full;
            dv_q    <= (state_d == LAUNCH);
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop) begin
                rptr_q   <= rptr_q + AW'(1);
                p_data_q <= mem_q[rptr_q];
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wr_data;
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer: inputs change and outputs are sampled on the
// falling edge; the transmitter side is modelled inline by driving tx_busy.
module tb_uart_tx_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       full, empty, overflow, tx_busy, data_valid;
    logic [3:0] count;
    logic [7:0] p_data;

    int n_chk = 0;
    int n_err = 0;

    uart_tx_buffer #(.DATA_WIDTH(8), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .tx_busy(tx_busy), .p_data(p_data), .data_valid(data_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // Waits for the next data_valid; returns the number of falling edges waited.
    task automatic wait_dv(output int cyc);
        cyc = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (data_valid) begin
                cyc = k;
                break;
            end
        end
        if (cyc == 0) chk("dv_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int   cyc;
        logic bad;
        logic [7:0] exp3 [3];
        exp3[0] = 8'h11; exp3[1] = 8'h22; exp3[2] = 8'h33;

        rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; tx_busy = 1'b0;
        tick(); tick();
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_dv", data_valid, 0);
        chk("rst_pdata", p_data, 0);

        // Single character, first edge after reset release.
        rst = 1'b1;
        wr(8'hA5);
        chk("single_count1", count, 1);
        chk("single_dv_early", data_valid, 0);
        tick();
        chk("single_dv", data_valid, 1);
        chk("single_pdata", p_data, 8'hA5);
        chk("single_count0", count, 0);
        tick();
        chk("single_dv_pulse", data_valid, 0);
        repeat (5) tick();

        // Handshake: transmitter busy for 10 cycles after each launch.
        tx_busy = 1'b1;
        wr(8'h11); wr(8'h22); wr(8'h33);
        chk("hs_count3", count, 3);
        tx_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_dv(cyc);
            chk("hs_pdata", p_data, exp3[i]);
            tx_busy = 1'b1;
            bad = 1'b0;
            repeat (10) begin
                tick();
                if (data_valid) bad = 1'b1;
            end
            chk("hs_no_launch_busy", bad, 0);
            tx_busy = 1'b0;
        end
        repeat (4) tick();
        chk("hs_empty", empty, 1);

        // Fill to full while the transmitter is busy, then overflow.
        tx_busy = 1'b1;
        for (int i = 0; i < 7; i++) wr(8'(i));
        chk("full_at7", full, 0);
        wr(8'h07);
        chk("full_at8", full, 1);
        chk("count_at8", count, 8);
        wr(8'h08);
        chk("ovf_pulse", overflow, 1);
        chk("ovf_count", count, 8);
        tick();
        chk("ovf_clear", overflow, 0);

        // Release with tx_busy held low: each launch relies on the WAIT_HI guard.
        tx_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wait_dv(cyc);
            chk("drain_pdata", p_data, 32'(i));
            if (i > 0) chk("guard_gap", cyc, 4);
        end
        repeat (5) tick();
        chk("drain_empty", empty, 1);
        chk("drain_count", count, 0);

        // Write on the same edge as a pop keeps count and launches the oldest.
        tx_busy = 1'b1;
        wr(8'h40); wr(8'h41); wr(8'h42);
        tx_busy = 1'b0;
        wr(8'h43);
        chk("sim_dv", data_valid, 1);
        chk("sim_pdata", p_data, 8'h40);
        chk("sim_count", count, 3);
        tx_busy = 1'b1;
        tick(); tick();
        wr(8'h44); wr(8'h45);
        chk("pre_rst_count", count, 5);

        // Asynchronous reset while waiting for tx_busy to fall.
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_dv", data_valid, 0);
        chk("mid_rst_pdata", p_data, 0);
        tick();
        rst = 1'b1;
        tx_busy = 1'b0;
        bad = 1'b0;
        repeat (10) begin
            tick();
            if (data_valid) bad = 1'b1;
        end
        chk("post_rst_no_launch", bad, 0);
        wr(8'h5A);
        wait_dv(cyc);
        chk("post_rst_latency", cyc, 1);
        chk("post_rst_pdata", p_data, 8'h5A);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
